data_mem_responder: RTL

//  Memory-side responder for the cpu data bus (write/read/address/dout -> din). Serves word-addressed

---
 rtl/data_mem_responder_pkg.sv | 49 ++++
 rtl/data_mem_responder_console_fifo.sv | 63 ++++++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared memory map for the data bus: I/O page base and offsets, TX status bit positions,
// and the address decoder used by the responder.
package data_mem_responder_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FF00;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_TXCTL  = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_TXCTL
  } sel_e;

  // Full 32-bit range checks; anything outside RAM and the four I/O words is unmapped.
  function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] io_base,
                                  input logic [31:0] ram_depth);
    logic [31:0] off;
    sel_e        sel;
    off = addr - io_base;
    sel = SEL_NONE;
    if (addr < ram_depth) begin
      sel = SEL_RAM;
    end else if (off[31:2] == 30'd0) begin
      case (off[1:0])
        OFF_LED:    sel = SEL_LED;
        OFF_CYCLE:  sel = SEL_CYCLE;
        OFF_TXDATA: sel = SEL_TXDATA;
        OFF_TXCTL:  sel = SEL_TXCTL;
        default:    sel = SEL_NONE;
      endcase
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Console TX byte FIFO. Pointers carry an extra wrap bit so full/empty need no separate flag;
// the head is read combinationally, so a pushed byte appears one cycle later.
module console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot in the same edge, so a push while full is accepted only alongside a pop.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus responder: word RAM plus an I/O page (LED, cycle counter, console TX FIFO).
// Reads are combinational because the cpu samples din in the same cycle it asserts read.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          RAM_DEPTH  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] address,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [15:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_err
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  sel_e           sel_s;
  logic [31:0]    ram_q [RAM_DEPTH];
  logic [15:0]    led_q, led_d;
  logic [31:0]    cycle_q;
  logic           ovf_q, ovf_d;
  logic           bus_err_q, bus_err_d;
  logic           push_s, pop_s, full_s, empty_s;
  logic [CW-1:0]  count_s;
  logic [31:0]    status_s;

  assign sel_s    = decode(address, IO_BASE, 32'(RAM_DEPTH));
  assign push_s   = write & (sel_s == SEL_TXDATA);
  assign pop_s    = tx_valid & tx_ready;
  assign tx_valid = ~empty_s;
  assign led      = led_q;
  assign bus_err  = bus_err_q;

  console_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (din[7:0]),
    .data_o  (tx_data),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  always_comb begin
    led_d     = led_q;
    ovf_d     = ovf_q;
    bus_err_d = bus_err_q;
    if (write && sel_s == SEL_LED) begin
      led_d = din[15:0];
    end else begin
      led_d = led_q;
    end
    // A dropped byte outranks a clear landing in the same cycle.
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (write && sel_s == SEL_TXCTL && din[0]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if ((read || write) && sel_s == SEL_NONE) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= 16'd0;
      cycle_q   <= 32'd0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_q + 32'd1;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write && sel_s == SEL_RAM) begin
      ram_q[address[RAM_AW-1:0]] <= din;
    end
  end

  always_comb begin
    status_s                       = 32'd0;
    status_s[ST_FULL]              = full_s;
    status_s[ST_EMPTY]             = empty_s;
    status_s[ST_OVF]               = ovf_q;
    status_s[ST_CNT_LSB +: 8]      = 8'(count_s);
  end

  always_comb begin
    dout = 32'd0;
    if (read) begin
      case (sel_s)
        SEL_RAM:    dout = ram_q[address[RAM_AW-1:0]];
        SEL_LED:    dout = {16'd0, led_q};
        SEL_CYCLE:  dout = cycle_q;
        SEL_TXDATA: dout = status_s;
        SEL_TXCTL:  dout = 32'd0;
        default:    dout = 32'd0;
      endcase
    end else begin
      dout = 32'd0;
    end
  end

endmodule
